mult8x8_accum: RTL and testbench

- Sits directly downstream of the 8-stage pipelined 8x8 unsigned multiplier (mult8x8), and wraps its issue side.
- Passes operands to the multiplier and carries a {valid,last} tag alongside them, delayed by the multiplier latency. The multiplier has no valid or reset of its own.
- Sums the aligned 16-bit products of each group into a wide accumulator.
- Emits one result per group through a small valid/ready result FIFO. Issue is throttled by credits so results are never lost.

---
 rtl/mult_pkg.sv | 33 +++
 rtl/mult_res_fifo.sv | 92 +++++++++
 rtl/mult_res_fifo_chk.sv | 16 +
 rtl/mult8x8_accum.sv | 170 +++++++++++++++++
 tb/tb_mult8x8_accum.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the 8x8 multiplier accumulate slice.
package mult_pkg;

  // Edges from operand sample to product update in the external mult8x8.
  localparam int MULT8_LAT = 8;
  // Product width of an 8x8 unsigned multiply.
  localparam int PROD_W = 16;
  // Default result field widths.
  localparam int RES_ACC_W = 24;
  localparam int RES_CNT_W = 8;

  // Side-band tag travelling alongside an operand pair through the multiplier.
  typedef struct packed {
    logic v;
    logic l;
  } tag_t;

  // One group result at the default widths.
  typedef struct packed {
    logic [RES_ACC_W-1:0] data;
    logic [RES_CNT_W-1:0] count;
    logic                 ovf;
  } res_t;

  // Build the issue-side tag; 'last' only counts when the beat is accepted.
  function automatic tag_t make_tag(input logic accepted, input logic last);
    tag_t t;
    t.v = accepted;
    t.l = last & accepted;
    return t;
  endfunction

endpackage

// File: rtl/mult_res_fifo.sv
// Small synchronous first-word fall-through FIFO holding finished group results.
// The head entry is read straight from the storage flops, so the output is
// stable while it waits for a pop. Simultaneous push and pop is legal at any
// occupancy; on an empty FIFO the push is kept and the pop is ignored.
module mult_res_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointer advance with wrap modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign full      = (occ_q == OCC_FULL);
  assign empty     = (occ_q == {OCC_W{1'b0}});
  assign push_ok_s = push & (~full | pop);
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // FIFO state registers; storage is cleared so the idle head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  mult_res_fifo_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .full  (full)
  );

endmodule

// File: rtl/mult_res_fifo_chk.sv
// Protocol checks for the result FIFO: a push must never meet a full FIFO
// unless a pop frees a slot in the same cycle.
module mult_res_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic pop,
  input logic full
);

  // Credit throttling upstream guarantees this can never fire.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && full && !pop)
  ) else $error("mult_res_fifo: push into full FIFO");

endmodule

// File: rtl/mult8x8_accum.sv
// Issue wrapper and group accumulator for the external pipelined mult8x8.
// A {valid,last} tag rides a shift register matched to the multiplier
// latency; when the tag emerges, the product beside it is summed into the
// running group total. Each closing beat pushes one result into a FIFO, and
// issue of closing beats is credit-limited so that FIFO can never overflow.
module mult8x8_accum
  import mult_pkg::*;
#(
  parameter int MULT_LAT  = MULT8_LAT,
  parameter int ACC_W     = RES_ACC_W,
  parameter int CNT_W     = RES_CNT_W,
  parameter int RES_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             in_ready,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [CNT_W-1:0] res_count,
  output logic             res_ovf
);

  localparam int CRD_W = $clog2(RES_DEPTH + 1);
  localparam logic [CRD_W-1:0] CRD_INIT = CRD_W'(RES_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } res_w_t;

  tag_t             tag_q [MULT_LAT];
  tag_t             tag_d [MULT_LAT];
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CRD_W-1:0] credits_q, credits_d;

  logic             acc_in_s;
  logic             pop_s;
  logic             push_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [ACC_W:0]   sum_s;
  logic [CNT_W-1:0] cnt_new_s;
  logic             ovf_new_s;
  res_w_t           push_res_s;
  res_w_t           head_res_s;
  tag_t             tag_out_s;

  assign in_ready  = (credits_q != {CRD_W{1'b0}});
  assign acc_in_s  = in_valid & in_ready;
  assign res_valid = ~fifo_empty_s;
  assign pop_s     = res_valid & res_ready;
  assign tag_out_s = tag_q[MULT_LAT-1];

  // Operands reach the multiplier only for accepted beats; idle cycles feed zeros.
  always_comb begin
    mul_a = 8'h00;
    mul_b = 8'h00;
    if (acc_in_s) begin
      mul_a = in_a;
      mul_b = in_b;
    end else begin
      mul_a = 8'h00;
      mul_b = 8'h00;
    end
  end

  // Tag shift register: the last stage lines up with mul_p.
  always_comb begin
    tag_d[0] = make_tag(acc_in_s, in_last);
    for (int i = 1; i < MULT_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Group arithmetic: the first term of a group restarts sum, count and overflow.
  always_comb begin
    sum_s     = {1'b0, (first_q ? {ACC_W{1'b0}} : acc_q)}
              + {{(ACC_W + 1 - PROD_W){1'b0}}, mul_p};
    ovf_new_s = (first_q ? 1'b0 : ovf_q) | sum_s[ACC_W];
    if (first_q) begin
      cnt_new_s = CNT_W'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_new_s = cnt_q;
    end else begin
      cnt_new_s = cnt_q + CNT_W'(1);
    end
  end

  // Accumulator update and result push on an aligned valid tag.
  always_comb begin
    acc_d      = acc_q;
    first_d    = first_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    push_s     = 1'b0;
    push_res_s = '{data: sum_s[ACC_W-1:0], count: cnt_new_s, ovf: ovf_new_s};
    if (tag_out_s.v) begin
      acc_d   = sum_s[ACC_W-1:0];
      cnt_d   = cnt_new_s;
      ovf_d   = ovf_new_s;
      first_d = tag_out_s.l;
      push_s  = tag_out_s.l;
    end else begin
      push_s = 1'b0;
    end
  end

  // Credits: a closing beat reserves a FIFO slot, a pop returns one.
  always_comb begin
    credits_d = credits_q;
    case ({acc_in_s & in_last, pop_s})
      2'b10:   credits_d = credits_q - CRD_W'(1);
      2'b01:   credits_d = credits_q + CRD_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  // State registers; clearing the tags discards products still in the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MULT_LAT; i++) begin
        tag_q[i] <= '0;
      end
      acc_q     <= {ACC_W{1'b0}};
      first_q   <= 1'b1;
      cnt_q     <= {CNT_W{1'b0}};
      ovf_q     <= 1'b0;
      credits_q <= CRD_INIT;
    end else begin
      tag_q     <= tag_d;
      acc_q     <= acc_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      credits_q <= credits_d;
    end
  end

  mult_res_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH ($bits(res_w_t))
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (push_res_s),
    .pop   (pop_s),
    .rdata (head_res_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign res_data  = head_res_s.data;
  assign res_count = head_res_s.count;
  assign res_ovf   = head_res_s.ovf;

endmodule

// File: tb/tb_mult8x8_accum.sv
// Directed bench for mult8x8_accum with a behavioural 8-stage multiplier.
module tb_mult8x8_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, in_ready;
  logic [7:0]  in_a, in_b, mul_a, mul_b;
  logic [15:0] mul_p;
  logic        res_valid, res_ready, res_ovf;
  logic [23:0] res_data;
  logic [7:0]  res_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [23:0] d;
    logic [7:0]  c;
    logic        o;
    int          t;
  } res_rec_t;
  res_rec_t q[$];

  mult8x8_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_count (res_count),
    .res_ovf   (res_ovf)
  );

  always #5 clk = ~clk;

  // Multiplier model: 8 registers, no reset, product valid 8 edges after sample.
  logic [15:0] pipe [8];
  always @(posedge clk) begin
    pipe[0] <= 16'(mul_a) * 16'(mul_b);
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p = pipe[7];

  // Cycle counter used to time-stamp popped results.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every result that will be popped at the coming edge.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready)
      q.push_back('{d: res_data, c: res_count, o: res_ovf, t: cyc});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) chk("send_timeout", 32'(n), 32'd0);
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_a = 8'd0; in_b = 8'd0;
  endtask

  task automatic wait_results(input string tag, input int n);
    int k;
    k = 0;
    while (q.size() < n && k < 60) begin tick(); k++; end
    if (q.size() < n) chk({tag, "_timeout"}, 32'(q.size()), 32'(n));
  endtask

  task automatic get_res(input string tag, input int ed, input int ec, input int eo);
    res_rec_t r;
    if (q.size() == 0) begin
      chk({tag, "_present"}, 32'(q.size()), 32'd1);
    end else begin
      r = q.pop_front();
      chk({tag, "_data"}, 32'(r.d), 32'(ed));
      chk({tag, "_count"}, 32'(r.c), 32'(ec));
      chk({tag, "_ovf"}, 32'(r.o), 32'(eo));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, hi;
    res_rec_t r1, r2;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_a = 8'd0; in_b = 8'd0; res_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);
    chk("rst_res_ovf", 32'(res_ovf), 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Three-term group; result appears on the 9th edge counting the accepting edge.
    send(8'd3, 8'd5, 1'b0);
    send(8'd10, 8'd10, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    repeat (7) tick();
    chk("lat_before", 32'(res_valid), 32'd0);
    tick();
    chk("lat_at", 32'(res_valid), 32'd1);
    wait_results("g1", 1);
    get_res("g1", 65140, 3, 0);

    // Back-to-back single-term groups pop on consecutive cycles.
    send(8'd0, 8'd0, 1'b1);
    send(8'd1, 8'd1, 1'b1);
    wait_results("b2b", 2);
    if (q.size() >= 2) chk("b2b_spacing", 32'(q[1].t - q[0].t), 32'd1);
    get_res("b2b0", 0, 1, 0);
    get_res("b2b1", 1, 1, 0);

    // 259 max terms: wraps 2^24, count saturates at 255, overflow flagged.
    for (int i = 0; i < 259; i++) send(8'd255, 8'd255, (i == 258) ? 1'b1 : 1'b0);
    send(8'd2, 8'd3, 1'b1);
    wait_results("sat", 2);
    get_res("sat", 64259, 255, 1);
    get_res("after_sat", 6, 1, 0);

    // Back-pressure: credits exhausted after two closing beats.
    res_ready = 1'b0;
    send(8'd7, 8'd7, 1'b1);
    send(8'd8, 8'd8, 1'b1);
    chk("bp_in_ready_lo", 32'(in_ready), 32'd0);
    in_a = 8'd9; in_b = 8'd9; in_last = 1'b1; in_valid = 1'b1;
    chk("bp_mul_a_gated", 32'(mul_a), 32'd0);
    repeat (12) tick();
    chk("bp_still_blocked", 32'(in_ready), 32'd0);
    chk("bp_head_valid", 32'(res_valid), 32'd1);
    chk("bp_head_data", 32'(res_data), 32'd49);
    res_ready = 1'b1;
    tick();
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    wait_results("bp", 3);
    get_res("bp0", 49, 1, 0);
    get_res("bp1", 64, 1, 0);
    get_res("bp2", 81, 1, 0);

    // Reset with four beats in the multiplier: nothing may emerge.
    for (int i = 0; i < 4; i++) send(8'd5, 8'd5, (i == 3) ? 1'b1 : 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (res_valid) hi++;
    end
    chk("flush_no_valid", 32'(hi), 32'd0);
    chk("flush_queue", 32'(q.size()), 32'd0);
    send(8'd4, 8'd4, 1'b1);
    wait_results("post_rst", 1);
    get_res("post_rst", 16, 1, 0);

    // Bubbles inside a group do not contribute.
    send(8'd2, 8'd2, 1'b0);
    tick(); tick();
    send(8'd3, 8'd3, 1'b1);
    wait_results("bubble", 1);
    get_res("bubble", 13, 2, 0);

    tick(); tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_res_valid", 32'(res_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
